// File: rtl/adc_spi_reader.sv
// adc_spi_reader: SPI master that repeatedly reads NBITS-bit words from an ADC (CPOL=0, MSB first).
module adc_spi_reader #(
    parameter int SCK_HALF = 2,
    parameter int NBITS    = 16,
    parameter int GAP      = 4
) (
    input  logic        clk_100,
    input  logic        reset,
    input  logic        start,
    input  logic        miso,
    output logic        sck,
    output logic        cs_n,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        busy
);
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_GAP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  bit_q, bit_d;
    logic [15:0] shreg_q, shreg_d;
    logic [15:0] data_q, data_d;
    logic        sck_q, sck_d;
    logic        cs_n_q, cs_n_d;
    logic        valid_q, valid_d;
    logic        half_done, gap_done;

    assign half_done  = cnt_q == 4'(SCK_HALF - 1);
    assign gap_done   = cnt_q == 4'(GAP - 1);
    assign sck        = sck_q;
    assign cs_n       = cs_n_q;
    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign busy       = !cs_n_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 4'd1;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        sck_d   = sck_q;
        cs_n_d  = cs_n_q;
        valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = S_SETUP;
                    cs_n_d  = 1'b0;
                    bit_d   = '0;
                    shreg_d = '0;
                end
            end
            S_SETUP, S_SHIFT: begin
                // A completing frame wins over a simultaneous start drop
                if (half_done && !sck_q && bit_q == 5'(NBITS)) begin
                    state_d = S_GAP;
                    cs_n_d  = 1'b1;
                    cnt_d   = '0;
                    data_d  = shreg_q;
                    valid_d = 1'b1;
                end else if (!start) begin
                    state_d = S_GAP;
                    cs_n_d  = 1'b1;
                    sck_d   = 1'b0;
                    cnt_d   = '0;
                end else if (half_done) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    sck_d   = !sck_q;
                    if (!sck_q) begin
                        shreg_d = {shreg_q[14:0], miso};
                        bit_d   = bit_q + 5'd1;
                    end
                end
            end
            S_GAP: begin
                if (gap_done) begin
                    cnt_d   = '0;
                    state_d = start ? S_SETUP : S_IDLE;
                    cs_n_d  = !start;
                    bit_d   = '0;
                    shreg_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_100) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            sck_q   <= 1'b0;
            cs_n_q  <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            sck_q   <= sck_d;
            cs_n_q  <= cs_n_d;
            valid_q <= valid_d;
        end
    end
endmodule
